// File: rtl/cu_arith_pkg.sv
// Purpose: shared compute-unit arithmetic definitions (adder width, arbiter states, clog2 helper).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cu_arith_pkg;

    localparam int ADDER_W = 32;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Ceiling log2, used to size requester IDs from the requester count.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/CSA.sv
// Purpose: 32-bit shared adder, A + B -> {Cout, Sum}, no carry-in.
// Latency: combinational.
// Backpressure: none.
// Ports: A, B operands; Sum low 32 bits of result; Cout carry out of bit 31.
module CSA (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Sum,
    output logic        Cout
);

    assign {Cout, Sum} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/rr_pick.sv
// Purpose: round-robin first-one search starting at prio_ptr, wrapping modulo NUM_REQ.
// Latency: combinational.
// Backpressure: none; caller decides whether the pick is accepted.
// Ports: req_valid (candidates), prio_ptr (search start) -> winner (index), any (some candidate valid).
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    prio_ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    int idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(prio_ptr) + k) % NUM_REQ;
            if (!any && req_valid[idx]) begin
                winner = ID_W'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csa_arbiter.sv
// Purpose: round-robin (with lock) sharing of one CSA adder between NUM_REQ requesters; one-entry result stage.
// Latency: 1 cycle from accepted beat to resp_*; 1 result/cycle while resp_ready is high.
// Backpressure: when the result stage is full and resp_ready is low, all req_ready drop and the FSM holds.
// Ports: req_valid/req_lock/req_a/req_b per requester (packed 32b lanes), req_ready one-hot grant;
//        resp_valid/resp_ready handshake with resp_sum/resp_cout/resp_id; locked shows the LOCKED state.
module csa_arbiter
    import cu_arith_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_lock,
    input  logic [NUM_REQ*ADDER_W-1:0]   req_a,
    input  logic [NUM_REQ*ADDER_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [ADDER_W-1:0]           resp_sum,
    output logic                         resp_cout,
    output logic [ID_W-1:0]              resp_id,
    output logic                         locked
);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     prio_q, prio_d;
    logic [ID_W-1:0]     owner_q, owner_d;

    logic                resp_vld_q;
    logic [ADDER_W-1:0]  resp_sum_q;
    logic                resp_cout_q;
    logic [ID_W-1:0]     resp_id_q;

    logic [ID_W-1:0]     pick_id;
    logic                pick_any;
    logic                can_issue;
    logic                grant_vld;
    logic [ID_W-1:0]     grant_id;

    logic [ADDER_W-1:0]  add_a, add_b, add_sum;
    logic                add_cout;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .prio_ptr  (prio_q),
        .winner    (pick_id),
        .any       (pick_any)
    );

    // Grant selection: round-robin pick in ARB, the owner only in LOCKED.
    // Operands never feed this path, so ready has no dependency on req_a/req_b.
    always_comb begin
        can_issue = !resp_vld_q || resp_ready;
        grant_id  = pick_id;
        grant_vld = can_issue && pick_any;
        if (state_q == ST_LOCKED) begin
            grant_id  = owner_q;
            grant_vld = can_issue && req_valid[owner_q];
        end
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Zero the adder inputs when idle so the shared adder does not toggle on stale lanes.
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (grant_vld) begin
            add_a = req_a[int'(grant_id)*ADDER_W +: ADDER_W];
            add_b = req_b[int'(grant_id)*ADDER_W +: ADDER_W];
        end
    end

    CSA u_csa (
        .A    (add_a),
        .B    (add_b),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    // Lock is sampled only on an accepted beat. The pointer advances only on ARB grants;
    // a locked run leaves it already pointing past the owner.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        if (grant_vld) begin
            if (state_q == ST_ARB) begin
                prio_d = ID_W'((int'(grant_id) + 1) % NUM_REQ);
            end
            if (req_lock[grant_id]) begin
                state_d = ST_LOCKED;
                owner_d = grant_id;
            end else begin
                state_d = ST_ARB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
            prio_q  <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
        end
    end

    // One-entry result stage; a new accept overwrites a result being drained in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_vld_q  <= 1'b0;
            resp_sum_q  <= '0;
            resp_cout_q <= 1'b0;
            resp_id_q   <= '0;
        end else if (grant_vld) begin
            resp_vld_q  <= 1'b1;
            resp_sum_q  <= add_sum;
            resp_cout_q <= add_cout;
            resp_id_q   <= grant_id;
        end else if (resp_ready) begin
            resp_vld_q  <= 1'b0;
        end
    end

    assign resp_valid = resp_vld_q;
    assign resp_sum   = resp_sum_q;
    assign resp_cout  = resp_cout_q;
    assign resp_id    = resp_id_q;
    assign locked     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_csa_arbiter.sv
// Purpose: self-checking bench for csa_arbiter against a behavioural arbitration/result model.
// Latency: n/a.
// Backpressure: resp_ready driven directly by the bench.
module tb_csa_arbiter;

    localparam int N = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_lock;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_sum;
    logic            resp_cout;
    logic [1:0]      resp_id;
    logic            locked;

    csa_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_lock   (req_lock),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_id    (resp_id),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: owner = -1 means nobody holds the adder.
    bit          m_vld;
    logic [31:0] m_sum;
    bit          m_cout;
    int          m_id;
    int          m_ptr;
    int          m_owner;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vld = 0; m_sum = 0; m_cout = 0; m_id = 0; m_ptr = 0; m_owner = -1;
    endtask

    task automatic set_req(input int i, input bit v, input bit lk, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]      = v;
        req_lock[i]       = lk;
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    // Who the rules say should win right now (-1 if nobody may be accepted).
    function automatic int model_winner();
        int w;
        w = -1;
        if (m_vld && !resp_ready) return -1;
        if (m_owner >= 0) begin
            if (req_valid[m_owner]) w = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
        end
        return w;
    endfunction

    // One clock: check ready mid-cycle, advance the model at the edge, check the result stage after it.
    task automatic cycle();
        int w;
        logic [32:0] full;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        w = model_winner();
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        #1;
        if (w >= 0) begin
            full = {1'b0, req_a[w*32 +: 32]} + {1'b0, req_b[w*32 +: 32]};
            m_sum = full[31:0];
            m_cout = full[32];
            m_id = w;
            m_vld = 1;
            if (m_owner < 0) m_ptr = (w + 1) % N;
            m_owner = req_lock[w] ? w : -1;
        end else if (resp_ready) begin
            m_vld = 0;
        end
        chk("resp_valid", 64'(resp_valid), 64'(m_vld));
        chk("locked", 64'(locked), 64'(m_owner >= 0));
        if (m_vld) begin
            chk("resp_sum", 64'(resp_sum), 64'(m_sum));
            chk("resp_cout", 64'(resp_cout), 64'(m_cout));
            chk("resp_id", 64'(resp_id), 64'(m_id));
        end
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_lock  = '0;
    endtask

    int exp_lock_id[7]  = '{1, 1, 1, 1, 2, 3, 0};
    bit exp_lock_lk[7]  = '{1, 1, 1, 0, 0, 0, 0};

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_lock = '0; req_a = '0; req_b = '0;
        resp_ready = 1'b1;
        model_reset();

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_sum", 64'(resp_sum), 64'd0);
        chk("rst_cout", 64'(resp_cout), 64'd0);
        chk("rst_id", 64'(resp_id), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        rst_n = 1'b1;

        // Requester 2 alone right after release
        set_req(2, 1, 0, 32'h0000_0005, 32'h0000_0007);
        #1;
        chk("first_ready", 64'(req_ready), 64'b0100);
        cycle();
        chk("first_sum", 64'(resp_sum), 64'h0000_000C);
        chk("first_cout", 64'(resp_cout), 64'd0);
        chk("first_id", 64'(resp_id), 64'd2);
        clear_reqs();

        // Carry-out corner cases
        set_req(0, 1, 0, 32'h8000_0000, 32'h8000_0000);
        cycle();
        chk("ovf0_sum", 64'(resp_sum), 64'd0);
        chk("ovf0_cout", 64'(resp_cout), 64'd1);
        clear_reqs();
        set_req(1, 1, 0, 32'hFFFF_FFFF, 32'h0000_0001);
        cycle();
        chk("ovf1_sum", 64'(resp_sum), 64'd0);
        chk("ovf1_cout", 64'(resp_cout), 64'd1);
        clear_reqs();
        // Requester 3 beat brings the pointer back to 0
        set_req(3, 1, 0, $urandom, $urandom);
        cycle();
        clear_reqs();

        // Fairness: all valid, no bubbles, 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) set_req(i, 1, 0, $urandom, $urandom);
            cycle();
            chk("fair_id", 64'(resp_id), 64'(k % 4));
            chk("fair_valid", 64'(resp_valid), 64'd1);
        end
        clear_reqs();
        // One requester-0 beat moves the pointer to 1
        set_req(0, 1, 0, $urandom, $urandom);
        cycle();

        // Lock: requester 1 holds for four beats, then 2,3,0
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < N; i++) set_req(i, 1, 0, $urandom, $urandom);
            req_lock[1] = (k < 3);
            cycle();
            chk("lock_id", 64'(resp_id), 64'(exp_lock_id[k]));
            chk("lock_flag", 64'(locked), 64'(exp_lock_lk[k]));
        end
        req_lock = '0;

        // Backpressure with full output, then drain plus accept in the same cycle
        resp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_id", 64'(resp_id), 64'd0);
        end
        resp_ready = 1'b1;
        cycle();
        chk("drain_valid", 64'(resp_valid), 64'd1);
        chk("drain_id", 64'(resp_id), 64'd1);

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < N; i++) begin
                set_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                        ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom,
                        $urandom);
            end
            resp_ready = $urandom_range(0, 3) != 0;
            cycle();
        end

        // Leave any lock: everyone valid and unlocked with the output draining
        resp_ready = 1'b1;
        for (int k = 0; k < N + 2; k++) begin
            for (int i = 0; i < N; i++) set_req(i, 1, 0, $urandom, $urandom);
            cycle();
        end
        clear_reqs();
        cycle();

        // Reset while locked on requester 3 with a result pending
        set_req(3, 1, 1, $urandom, $urandom);
        cycle();
        chk("pre_rst_locked", 64'(locked), 64'd1);
        clear_reqs();
        resp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_locked", 64'(locked), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        set_req(0, 1, 0, $urandom, $urandom);
        set_req(3, 1, 0, $urandom, $urandom);
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'b0001);
        cycle();
        chk("post_rst_id", 64'(resp_id), 64'd0);
        chk("post_rst_locked", 64'(locked), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
